// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder: 32-bit LSB-first frames (4-bit address, 28-bit data) onto a bank of
// config registers plus one read-only status word. All SPI pins are oversampled on sysclk.
module spi_reg_responder #(
    parameter int         NUM_REGS = 8,
    parameter logic [3:0] READ_CMD = 4'hE
) (
    input  logic                        sysclk,
    input  logic                        reset_INV,
    input  logic                        spi_clk,
    input  logic                        spi_cs_INV,
    input  logic                        spi_mosi,
    output logic                        spi_miso,
    output logic [28*(NUM_REGS-1)-1:0]  cfg_out,
    input  logic [27:0]                 status_in,
    output logic                        wr_strobe,
    output logic [2:0]                  wr_addr,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int DATA_W = 28;
    localparam int NUM_WR = NUM_REGS - 1;

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;
    localparam logic [1:0] ST_COMMIT    = 2'd3;

    localparam logic [5:0] BIT_FULL = 6'd32;
    localparam logic [5:0] BIT_SAT  = 6'd33;

    // Pin synchronisers: [0] and [1] are the two sync flops, [2] is the edge-detect history.
    logic [2:0] sclk_sync_reg;
    logic [2:0] cs_sync_reg;
    logic [1:0] mosi_sync_reg;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_synced;
    logic cs_rise;
    logic cs_fall;
    logic mosi_synced;

    always_ff @(posedge sysclk) begin
        if (!reset_INV) begin
            sclk_sync_reg <= '0;
            cs_sync_reg   <= '0;
            mosi_sync_reg <= '0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], spi_clk};
            cs_sync_reg   <= {cs_sync_reg[1:0], spi_cs_INV};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
        end
    end

    assign sclk_rise   =  sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall   = ~sclk_sync_reg[1] &  sclk_sync_reg[2];
    assign cs_synced   =  cs_sync_reg[1];
    assign cs_rise     =  cs_sync_reg[1] & ~cs_sync_reg[2];
    assign cs_fall     = ~cs_sync_reg[1] &  cs_sync_reg[2];
    assign mosi_synced =  mosi_sync_reg[1];

    logic [1:0]  state_reg,     state_next;
    logic [5:0]  bit_cnt_reg,   bit_cnt_next;
    logic [31:0] rx_reg,        rx_next;
    logic [31:0] tx_shift_reg,  tx_shift_next;
    logic        miso_reg,      miso_next;
    logic [31:0] rd_word_reg,   rd_word_next;
    logic        rd_arm_reg,    rd_arm_next;
    logic        cs_pend_reg,   cs_pend_next;
    logic        wr_strobe_reg, wr_strobe_next;
    logic [2:0]  wr_addr_reg,   wr_addr_next;
    logic        frame_err_reg, frame_err_next;

    logic [3:0]        commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic [3:0]        rd_idx;
    logic              commit_is_write;
    logic              cfg_we;
    logic [DATA_W-1:0] rd_data;
    logic [31:0]       rd_word;
    logic [31:0]       tx_load;

    assign commit_addr     = rx_reg[3:0];
    assign commit_data     = rx_reg[31:4];
    assign rd_idx          = rx_reg[7:4];
    assign commit_is_write = (commit_addr < 4'(NUM_WR));
    assign cfg_we          = (state_reg == ST_COMMIT) && commit_is_write;
    assign tx_load         = rd_arm_reg ? rd_word_reg : 32'h0;

    // Writable config registers, each driving its own slice of cfg_out.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : gen_cfg
            logic [DATA_W-1:0] cfg_q;
            always_ff @(posedge sysclk) begin
                if (!reset_INV) begin
                    cfg_q <= '0;
                end else if (cfg_we && (commit_addr[2:0] == 3'(gi))) begin
                    cfg_q <= commit_data;
                end
            end
            assign cfg_out[DATA_W*gi +: DATA_W] = cfg_q;
        end
    endgenerate

    // Readback source: config register, status word, or zero for an out-of-range index.
    always_comb begin
        rd_data = '0;
        if (rd_idx < 4'(NUM_WR)) begin
            rd_data = cfg_out[DATA_W*rd_idx[2:0] +: DATA_W];
        end else if (rd_idx == 4'(NUM_WR)) begin
            rd_data = status_in;
        end
    end

    assign rd_word = (rd_idx <= 4'(NUM_WR)) ? {rd_data, rd_idx} : 32'h0;

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_shift_next  = tx_shift_reg;
        miso_next      = miso_reg;
        rd_word_next   = rd_word_reg;
        rd_arm_next    = rd_arm_reg;
        cs_pend_next   = cs_pend_reg;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr_reg;
        frame_err_next = 1'b0;

        case (state_reg)
            ST_WAIT_IDLE: begin
                miso_next    = 1'b0;
                cs_pend_next = 1'b0;
                if (cs_synced) begin
                    state_next = ST_IDLE;
                end
            end

            ST_IDLE: begin
                miso_next    = 1'b0;
                cs_pend_next = 1'b0;
                if (cs_fall || cs_pend_reg) begin
                    state_next    = ST_SHIFT;
                    bit_cnt_next  = '0;
                    rx_next       = '0;
                    tx_shift_next = tx_load;
                    miso_next     = tx_load[0];
                end
            end

            ST_SHIFT: begin
                // cs has priority over a coincident SCLK edge.
                if (cs_rise) begin
                    rd_arm_next = 1'b0;
                    miso_next   = 1'b0;
                    if (bit_cnt_reg == BIT_FULL) begin
                        state_next = ST_COMMIT;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_IDLE;
                    end
                end else if (sclk_rise) begin
                    if (bit_cnt_reg < BIT_FULL) begin
                        rx_next[bit_cnt_reg[4:0]] = mosi_synced;
                    end
                    if (bit_cnt_reg != BIT_SAT) begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                    end
                end else if (sclk_fall) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    miso_next     = tx_shift_reg[1];
                end
            end

            ST_COMMIT: begin
                state_next = ST_IDLE;
                miso_next  = 1'b0;
                // A new frame may start while we commit; remember it for IDLE.
                if (cs_fall) begin
                    cs_pend_next = 1'b1;
                end
                if (commit_is_write) begin
                    wr_strobe_next = 1'b1;
                    wr_addr_next   = commit_addr[2:0];
                end else if (commit_addr == READ_CMD) begin
                    rd_arm_next  = 1'b1;
                    rd_word_next = rd_word;
                end
            end

            default: begin
                state_next = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_INV) begin
            state_reg     <= ST_WAIT_IDLE;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            tx_shift_reg  <= '0;
            miso_reg      <= 1'b0;
            rd_word_reg   <= '0;
            rd_arm_reg    <= 1'b0;
            cs_pend_reg   <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_shift_reg  <= tx_shift_next;
            miso_reg      <= miso_next;
            rd_word_reg   <= rd_word_next;
            rd_arm_reg    <= rd_arm_next;
            cs_pend_reg   <= cs_pend_next;
            wr_strobe_reg <= wr_strobe_next;
            wr_addr_reg   <= wr_addr_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign spi_miso  = miso_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_COMMIT);

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: an SPI master model drives frames, a register model predicts
// writes and readbacks, and a scoreboard compares them with what the responder produces.
module tb_spi_reg_responder;

    logic         sysclk = 1'b0;
    logic         reset_INV = 1'b0;
    logic         spi_clk = 1'b0;
    logic         spi_cs_INV = 1'b1;
    logic         spi_mosi = 1'b0;
    logic         spi_miso;
    logic [195:0] cfg_out;
    logic [27:0]  status_in = 28'h0;
    logic         wr_strobe;
    logic [2:0]   wr_addr;
    logic         frame_err;
    logic         busy;

    always #5 sysclk = ~sysclk;

    spi_reg_responder dut (
        .sysclk     (sysclk),
        .reset_INV  (reset_INV),
        .spi_clk    (spi_clk),
        .spi_cs_INV (spi_cs_INV),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .cfg_out    (cfg_out),
        .status_in  (status_in),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    localparam int RAND_FRAMES = 250;
    localparam logic [31:0] DUMMY = 32'hFFFFFFF7;

    int tests_run = 0;
    int tests_failed = 0;

    logic [27:0] model_reg [7];
    logic        model_arm;
    logic [31:0] model_word;
    logic [30:0] exp_wr_q [$];
    logic [31:0] exp_rd_q [$];
    int          exp_ferr = 0;
    int          seen_ferr = 0;
    int          frame_no = 0;
    logic        busy_mid;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    function automatic logic [195:0] model_cfg();
        logic [195:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r[28*i +: 28] = model_reg[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) model_reg[i] = 28'h0;
        model_arm  = 1'b0;
        model_word = 32'h0;
    endtask

    // Write monitor: every wr_strobe must match the oldest predicted write.
    always @(negedge sysclk) begin
        if (reset_INV) begin
            if (frame_err) seen_ferr++;
            if (wr_strobe) begin
                logic [30:0] e;
                check("strobe_excl", frame_err, 1'b0);
                check("wr_q_nonempty", exp_wr_q.size() > 0, 1'b1);
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", wr_addr, e[30:28]);
                    check("wr_data", cfg_out[28*wr_addr +: 28], e[27:0]);
                end
            end
        end
    end

    // SPI master, mode 0, SCLK = sysclk/6; MISO is sampled just before each rising edge.
    task automatic run_frame(input logic [31:0] word, input int nbits, input int rst_bit,
                             output logic [31:0] got);
        got = 32'h0;
        spi_mosi = word[0];
        spi_cs_INV = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                reset_INV = 1'b0;
                tick(1);
                reset_INV = 1'b1;
            end
            if (i < 32) got[i] = spi_miso;
            if (i == 16) busy_mid = busy;
            spi_clk = 1'b1;
            tick(3);
            spi_clk = 1'b0;
            if (i + 1 < 32) spi_mosi = word[i+1];
            else spi_mosi = 1'b0;
            tick(3);
        end
        spi_cs_INV = 1'b1;
    endtask

    task automatic do_frame(input logic [31:0] word, input int nbits, input int gap,
                            output logic [31:0] got);
        logic [31:0] exp;
        logic [31:0] mask;
        logic [3:0]  addr;
        logic [3:0]  idx;
        exp_rd_q.push_back(model_arm ? model_word : 32'h0);
        run_frame(word, nbits, -1, got);
        model_arm = 1'b0;
        if (nbits == 32) begin
            addr = word[3:0];
            idx  = word[7:4];
            if (addr < 4'd7) begin
                model_reg[addr[2:0]] = word[31:4];
                exp_wr_q.push_back({addr[2:0], word[31:4]});
            end else if (addr == 4'hE) begin
                model_arm = 1'b1;
                if (idx < 4'd7) model_word = {model_reg[idx[2:0]], idx};
                else if (idx == 4'd7) model_word = {status_in, idx};
                else model_word = 32'h0;
            end
        end else begin
            exp_ferr++;
        end
        mask = (nbits >= 32) ? 32'hFFFFFFFF : ((32'h1 << nbits) - 32'h1);
        exp = exp_rd_q.pop_front();
        check("miso_frame", got & mask, exp & mask);
        $display("[TB] frame %0d mosi=%08h bits=%0d miso=%08h", frame_no, word, nbits, got);
        frame_no++;
        tick(gap);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  got;
        logic [195:0] m;
        int           f0;
        int           op;
        int           nb;
        logic [3:0]   a;
        logic [31:0]  w;

        model_reset();
        reset_INV = 1'b0;
        tick(5);
        reset_INV = 1'b1;
        tick(1);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_cfg_out", cfg_out, 196'h0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 3'h0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick(6);

        // Single write to reg 2
        do_frame(32'hABCDEF12, 32, 8, got);
        check("t1_busy", busy_mid, 1'b1);
        check("t1_reg2", cfg_out[56 +: 28], 28'hABCDEF1);
        m = '0;
        m[56 +: 28] = '1;
        check("t1_others", cfg_out & ~m, 196'h0);
        check("t1_cfg", cfg_out, model_cfg());

        // Write, read command, readback, then consumed arm
        do_frame(32'h12345673, 32, 8, got);
        do_frame(32'h0000003E, 32, 8, got);
        do_frame(DUMMY, 32, 8, got);
        check("t2_readback", got, 32'h12345673);
        do_frame(DUMMY, 32, 8, got);
        check("t2_consumed", got, 32'h0);

        // Status word readback
        status_in = 28'h0C0FFEE;
        do_frame(32'h0000007E, 32, 8, got);
        do_frame(DUMMY, 32, 8, got);
        check("t3_status", got, 32'h0C0FFEE7);

        // Short and long frames
        do_frame(32'h11111111, 32, 8, got);
        f0 = seen_ferr;
        do_frame(32'h76543211, 31, 8, got);
        do_frame(32'h76543211, 33, 8, got);
        check("t4_ferr", seen_ferr - f0, 2);
        check("t4_reg1", cfg_out[28 +: 28], 28'h1111111);
        check("t4_cfg", cfg_out, model_cfg());

        // Reset in the middle of a write frame
        f0 = seen_ferr;
        run_frame(32'h9ABCDEF5, 32, 10, got);
        model_reset();
        $display("[TB] frame %0d mosi=%08h bits=32 reset at bit 10", frame_no, 32'h9ABCDEF5);
        frame_no++;
        tick(8);
        check("t5_cfg_cleared", cfg_out, 196'h0);
        check("t5_no_ferr", seen_ferr - f0, 0);
        do_frame(32'h5A5A5A54, 32, 8, got);
        check("t5_reg4", cfg_out[112 +: 28], 28'h5A5A5A5);
        check("t5_cfg", cfg_out, model_cfg());

        // Random traffic with short cs gaps
        status_in = 28'($urandom);
        for (int n = 0; n < RAND_FRAMES; n++) begin
            op = $urandom_range(0, 99);
            nb = 32;
            w  = $urandom;
            if (op < 45) begin
                a = 4'($urandom_range(0, 6));
                w = {w[31:4], a};
            end else if (op < 75) begin
                w = {w[31:8], 4'($urandom_range(0, 15)), 4'hE};
            end else if (op < 92) begin
                a = 4'($urandom_range(7, 15));
                if (a == 4'hE) a = 4'hF;
                w = {w[31:4], a};
            end else begin
                nb = $urandom_range(20, 39);
                if (nb == 32) nb = 40;
            end
            do_frame(w, nb, $urandom_range(1, 5), got);
        end
        tick(10);
        check("rand_cfg", cfg_out, model_cfg());
        check("ferr_total", seen_ferr, exp_ferr);
        check("wr_q_drained", exp_wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
